// File: rtl/flash_defs.sv
// Shared definitions for the NOR flash read/write sequencer: state encodings,
// flash bus widths and strobe idle levels.
package flash_defs;

    localparam int FLASH_AW = 22;
    localparam int FLASH_DW = 16;

    localparam logic STROBE_IDLE = 1'b1;
    localparam logic STROBE_ACT  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_LO    = 3'd1,
        ST_RD_HI    = 3'd2,
        ST_DONE     = 3'd3,
        ST_WR_SETUP = 3'd4,
        ST_WR_PULSE = 3'd5,
        ST_WR_HOLD  = 3'd6
    } flash_state_e;

endpackage

// File: rtl/flash_wait_cnt.sv
// Loadable down-counter with a zero flag; times each flash access phase.
// Decrement saturates at zero so a held dec never wraps.
module flash_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/flash_ctrl.sv
// NOR flash sequencer: one 32-bit read becomes two timed 16-bit accesses.
// Define FLASH_WRITE_EN to enable single-halfword write cycles.
module flash_ctrl
    import flash_defs::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int ADDR_W      = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [15:0]         wdata_i,
    output logic [31:0]         rdata_o,
    output logic                ack_o,
    output logic                busy_o,
    output logic [FLASH_AW-1:0] flash_a,
    inout  wire  [FLASH_DW-1:0] flash_data,
    output logic                flash_ce_n,
    output logic                flash_oe_n,
    output logic                flash_we_n,
    output logic                flash_rp_n,
    output logic                flash_byte_n,
    output logic [2:0]          dbg_state
);

    // A zero wait setting is treated as a single-cycle access.
    localparam int         WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam logic [3:0] RELOAD   = 4'(WAIT_EFF - 1);

    flash_state_e          state, state_nx;
    logic [31:0]           rdata_nx;
    logic                  ack_nx, busy_nx;
    logic [FLASH_AW-1:0]   fa_nx;
    logic                  ce_nx, oe_nx, we_nx, drv_nx;
    logic                  we_q, drv_q;
    logic [FLASH_DW-1:0]   wd_q, wd_nx;
    logic                  cnt_load, cnt_dec, cnt_zero;
    logic [3:0]            cnt_val;

    flash_wait_cnt #(.W(4)) u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst),
        .load     (cnt_load),
        .load_val (RELOAD),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rdata_nx = rdata_o;
        ack_nx   = 1'b0;
        busy_nx  = busy_o;
        fa_nx    = flash_a;
        ce_nx    = flash_ce_n;
        oe_nx    = flash_oe_n;
        we_nx    = we_q;
        drv_nx   = drv_q;
        wd_nx    = wd_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_nx = 1'b0;
                if (req_i && !we_i) begin
                    state_nx = ST_RD_LO;
                    fa_nx    = {addr_i[22:2], 1'b0};
                    ce_nx    = STROBE_ACT;
                    oe_nx    = STROBE_ACT;
                    cnt_load = 1'b1;
                    busy_nx  = 1'b1;
                end else if (req_i && we_i) begin
                    busy_nx = 1'b1;
`ifdef FLASH_WRITE_EN
                    state_nx = ST_WR_SETUP;
                    fa_nx    = addr_i[22:1];
                    ce_nx    = STROBE_ACT;
                    drv_nx   = 1'b1;
                    wd_nx    = wdata_i;
`else
                    state_nx = ST_DONE;
`endif
                end
            end
            // ce_n/oe_n stay low while flash_a[0] flips to the upper half.
            ST_RD_LO: begin
                if (cnt_zero) begin
                    rdata_nx[15:0] = flash_data;
                    fa_nx[0]       = 1'b1;
                    cnt_load       = 1'b1;
                    state_nx       = ST_RD_HI;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RD_HI: begin
                if (cnt_zero) begin
                    rdata_nx[31:16] = flash_data;
                    ce_nx           = STROBE_IDLE;
                    oe_nx           = STROBE_IDLE;
                    ack_nx          = 1'b1;
                    state_nx        = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            // Paths that arrive without ack raised spend one extra cycle here.
            ST_DONE: begin
                if (!ack_o) begin
                    ack_nx = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                    busy_nx  = 1'b0;
                end
            end
`ifdef FLASH_WRITE_EN
            ST_WR_SETUP: begin
                we_nx    = STROBE_ACT;
                cnt_load = 1'b1;
                state_nx = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (cnt_zero) begin
                    we_nx    = STROBE_IDLE;
                    state_nx = ST_WR_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WR_HOLD: begin
                ce_nx    = STROBE_IDLE;
                drv_nx   = 1'b0;
                ack_nx   = 1'b1;
                state_nx = ST_DONE;
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_o    <= '0;
            ack_o      <= 1'b0;
            busy_o     <= 1'b0;
            flash_a    <= '0;
            flash_ce_n <= STROBE_IDLE;
            flash_oe_n <= STROBE_IDLE;
            flash_rp_n <= 1'b0;
            we_q       <= STROBE_IDLE;
            drv_q      <= 1'b0;
            wd_q       <= '0;
        end else begin
            rdata_o    <= rdata_nx;
            ack_o      <= ack_nx;
            busy_o     <= busy_nx;
            flash_a    <= fa_nx;
            flash_ce_n <= ce_nx;
            flash_oe_n <= oe_nx;
            flash_rp_n <= 1'b1;
            we_q       <= we_nx;
            drv_q      <= drv_nx;
            wd_q       <= wd_nx;
        end
    end

`ifdef FLASH_WRITE_EN
    assign flash_we_n = we_q;
    assign flash_data = drv_q ? wd_q : 'z;
    logic unused_bits;
    assign unused_bits = ^{addr_i, cnt_val};
`else
    assign flash_we_n = STROBE_IDLE;
    assign flash_data = 'z;
    logic unused_bits;
    assign unused_bits = ^{addr_i, wdata_i, cnt_val, we_q, drv_q, wd_q};
`endif

    assign flash_byte_n = 1'b1;
    assign dbg_state    = state;

endmodule
